// File: rtl/fetch_unit_if.sv
// Fetch-stage bundle: instruction memory bus, decode handshake and redirect input.
// The master modport is the fetch unit; the slave modport is memory/decode/branch logic.
interface fetch_unit_if #(
  parameter int AW    = 32,
  parameter int BUS_W = 16,
  parameter int ILEN  = 32
);
  logic             redirect_valid;
  logic [AW-1:0]    redirect_pc;
  logic             mem_req;
  logic [AW-1:0]    mem_addr;
  logic             mem_ack;
  logic [BUS_W-1:0] mem_rdata;
  logic             instr_valid;
  logic             instr_ready;
  logic [ILEN-1:0]  instr_data;
  logic [AW-1:0]    instr_pc;

  modport master (
    input  redirect_valid, redirect_pc, mem_ack, mem_rdata, instr_ready,
    output mem_req, mem_addr, instr_valid, instr_data, instr_pc
  );

  modport slave (
    output redirect_valid, redirect_pc, mem_ack, mem_rdata, instr_ready,
    input  mem_req, mem_addr, instr_valid, instr_data, instr_pc
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC and assembles ILEN/BUS_W bus beats into one
// instruction, with redirect handling and a valid/ready hand-off to decode.
//
// state | meaning
// FETCH | requesting beats of the instruction at pc
// OUT   | instruction held for decode until accepted or redirected
// DRAIN | redirected mid-beat; wait out the pending ack, then discard it
module fetch_unit #(
  parameter int          AW       = 32,
  parameter int          BUS_W    = 16,
  parameter int          ILEN     = 32,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         reset,
  fetch_unit_if.master bus
);

  localparam int BEATS  = ILEN / BUS_W;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  localparam logic [AW-1:0]     PC_RST     = AW'(RESET_PC);
  localparam logic [AW-1:0]     BEAT_BYTES = AW'(BUS_W / 8);
  localparam logic [BEAT_W-1:0] LAST_BEAT  = BEAT_W'(BEATS - 1);

  localparam logic [1:0] S_FETCH = 2'd0;
  localparam logic [1:0] S_OUT   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]        state;
  logic [AW-1:0]     pc;
  logic [BEAT_W-1:0] beat;
  logic [AW-1:0]     drain_addr;
  logic              started;
  logic              instr_valid;
  logic [ILEN-1:0]   instr_data;
  logic [AW-1:0]     instr_pc;

  logic [AW-1:0]     redir_pc;
  logic [AW-1:0]     beat_addr;
  logic              mem_req;
  logic              ack;

  assign redir_pc  = {bus.redirect_pc[AW-1:2], 2'b00};
  assign beat_addr = pc + AW'(beat) * BEAT_BYTES;

  // started keeps the request low for the first cycle out of reset
  assign mem_req = started && ((state == S_FETCH) || (state == S_DRAIN));
  assign ack     = mem_req && bus.mem_ack;

  assign bus.mem_req     = mem_req;
  assign bus.mem_addr    = (state == S_DRAIN) ? drain_addr : beat_addr;
  assign bus.instr_valid = instr_valid;
  assign bus.instr_data  = instr_data;
  assign bus.instr_pc    = instr_pc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_FETCH;
      pc          <= PC_RST;
      beat        <= '0;
      drain_addr  <= PC_RST;
      started     <= 1'b0;
      instr_valid <= 1'b0;
      instr_data  <= '0;
      instr_pc    <= '0;
    end else begin
      started <= 1'b1;
      case (state)
        S_FETCH: begin
          if (bus.redirect_valid) begin
            pc   <= redir_pc;
            beat <= '0;
            // an outstanding beat must still complete on the bus, at its old address
            if (mem_req && !bus.mem_ack) begin
              drain_addr <= beat_addr;
              state      <= S_DRAIN;
            end
          end else if (ack) begin
            instr_data[int'(beat)*BUS_W +: BUS_W] <= bus.mem_rdata;
            if (beat == LAST_BEAT) begin
              instr_pc    <= pc;
              pc          <= pc + AW'(4);
              instr_valid <= 1'b1;
              state       <= S_OUT;
            end else begin
              beat <= beat + 1'b1;
            end
          end
        end
        S_OUT: begin
          if (bus.redirect_valid) begin
            pc          <= redir_pc;
            beat        <= '0;
            instr_valid <= 1'b0;
            state       <= S_FETCH;
          end else if (bus.instr_ready) begin
            beat        <= '0;
            instr_valid <= 1'b0;
            state       <= S_FETCH;
          end
        end
        S_DRAIN: begin
          if (bus.redirect_valid) pc <= redir_pc;
          if (ack) begin
            beat  <= '0;
            state <= S_FETCH;
          end
        end
        default: state <= S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a 16-bit bus instance (RESET_PC=0x100) and a 32-bit bus
// instance (RESET_PC=0xFFFF_FFFC), both on the same clock and reset.
module tb_fetch_unit;

  logic clk = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  fetch_unit_if #(.AW(32), .BUS_W(16), .ILEN(32)) b16 ();
  fetch_unit_if #(.AW(32), .BUS_W(32), .ILEN(32)) b32 ();

  fetch_unit #(.AW(32), .BUS_W(16), .ILEN(32), .RESET_PC(32'h0000_0100)) dut16 (
    .clk(clk), .reset(reset), .bus(b16)
  );
  fetch_unit #(.AW(32), .BUS_W(32), .ILEN(32), .RESET_PC(32'hFFFF_FFFC)) dut32 (
    .clk(clk), .reset(reset), .bus(b32)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b0;
    b16.redirect_valid = 1'b0; b16.redirect_pc = '0; b16.mem_ack = 1'b0;
    b16.mem_rdata = '0; b16.instr_ready = 1'b0;
    b32.redirect_valid = 1'b0; b32.redirect_pc = '0; b32.mem_ack = 1'b0;
    b32.mem_rdata = '0; b32.instr_ready = 1'b0;
    repeat (2) tick();

    check("rst_req",   b16.mem_req, 0);
    check("rst_addr",  b16.mem_addr, 32'h100);
    check("rst_valid", b16.instr_valid, 0);
    check("rst_data",  b16.instr_data, 0);
    check("rst_pc",    b16.instr_pc, 0);

    // 1: release, two zero-wait beats
    reset = 1'b1;
    #1;
    check("rel_req_low", b16.mem_req, 0);
    tick();
    check("t1_req0",  b16.mem_req, 1);
    check("t1_addr0", b16.mem_addr, 32'h100);
    b16.mem_ack = 1'b1; b16.mem_rdata = 16'hBEEF;
    tick();
    check("t1_req1",  b16.mem_req, 1);
    check("t1_addr1", b16.mem_addr, 32'h102);
    check("t1_noval", b16.instr_valid, 0);
    b16.mem_rdata = 16'hDEAD;
    tick();
    b16.mem_ack = 1'b0;
    check("t1_valid", b16.instr_valid, 1);
    check("t1_data",  b16.instr_data, 32'hDEADBEEF);
    check("t1_pc",    b16.instr_pc, 32'h100);
    check("t1_req_o", b16.mem_req, 0);

    // 2: back-pressure
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t2_valid", b16.instr_valid, 1);
      check("t2_data",  b16.instr_data, 32'hDEADBEEF);
      check("t2_pc",    b16.instr_pc, 32'h100);
      check("t2_req",   b16.mem_req, 0);
    end
    b16.instr_ready = 1'b1;
    tick();
    b16.instr_ready = 1'b0;
    check("t2_drop",  b16.instr_valid, 0);
    check("t2_req_n", b16.mem_req, 1);
    check("t2_addr_n", b16.mem_addr, 32'h104);

    // 3: redirect while beat 1 is stalled
    b16.mem_ack = 1'b1; b16.mem_rdata = 16'h1111;
    tick();
    b16.mem_ack = 1'b0;
    check("t3_addr1", b16.mem_addr, 32'h106);
    repeat (2) tick();
    check("t3_stall_addr", b16.mem_addr, 32'h106);
    check("t3_stall_req",  b16.mem_req, 1);
    b16.redirect_valid = 1'b1; b16.redirect_pc = 32'h203;
    tick();
    b16.redirect_valid = 1'b0;
    check("t3_drain_req",  b16.mem_req, 1);
    check("t3_drain_addr", b16.mem_addr, 32'h106);
    check("t3_drain_val",  b16.instr_valid, 0);
    tick();
    check("t3_drain_hold", b16.mem_addr, 32'h106);
    b16.mem_ack = 1'b1; b16.mem_rdata = 16'h2222;
    tick();
    b16.mem_ack = 1'b0;
    check("t3_new_addr", b16.mem_addr, 32'h200);
    check("t3_new_req",  b16.mem_req, 1);
    check("t3_noval",    b16.instr_valid, 0);
    b16.mem_ack = 1'b1; b16.mem_rdata = 16'h3333;
    tick();
    check("t3_addr_b1", b16.mem_addr, 32'h202);
    check("t3_noval2",  b16.instr_valid, 0);
    b16.mem_rdata = 16'h4444;
    tick();
    b16.mem_ack = 1'b0;
    check("t3_valid", b16.instr_valid, 1);
    check("t3_data",  b16.instr_data, 32'h44443333);
    check("t3_pc",    b16.instr_pc, 32'h200);

    // 4: redirect coincides with accept
    b16.instr_ready = 1'b1; b16.redirect_valid = 1'b1; b16.redirect_pc = 32'h80;
    tick();
    b16.instr_ready = 1'b0; b16.redirect_valid = 1'b0;
    check("t4_valid", b16.instr_valid, 0);
    check("t4_req",   b16.mem_req, 1);
    check("t4_addr",  b16.mem_addr, 32'h80);
    b16.mem_ack = 1'b1; b16.mem_rdata = 16'h5555;
    tick();
    b16.mem_rdata = 16'h6666;
    tick();
    b16.mem_ack = 1'b0;
    check("t4_data", b16.instr_data, 32'h66665555);
    check("t4_pc",   b16.instr_pc, 32'h80);
    b16.instr_ready = 1'b1;
    tick();
    b16.instr_ready = 1'b0;
    check("t4_next_addr", b16.mem_addr, 32'h84);

    // 6: async reset mid-beat, then restart
    b16.mem_ack = 1'b1; b16.mem_rdata = 16'h7777;
    tick();
    b16.mem_ack = 1'b0;
    check("t6_addr1", b16.mem_addr, 32'h86);
    #2 reset = 1'b0;
    #1;
    check("t6_req",   b16.mem_req, 0);
    check("t6_addr",  b16.mem_addr, 32'h100);
    check("t6_valid", b16.instr_valid, 0);
    check("t6_data",  b16.instr_data, 0);
    check("t6_pc",    b16.instr_pc, 0);
    tick();
    reset = 1'b1;
    tick();
    check("t6_restart_req",  b16.mem_req, 1);
    check("t6_restart_addr", b16.mem_addr, 32'h100);

    // 5: 32-bit bus, PC wrap, redirect with ack in the same cycle
    check("t5_req",  b32.mem_req, 1);
    check("t5_addr", b32.mem_addr, 32'hFFFF_FFFC);
    b32.mem_ack = 1'b1; b32.mem_rdata = 32'hCAFEF00D;
    tick();
    b32.mem_ack = 1'b0;
    check("t5_valid", b32.instr_valid, 1);
    check("t5_data",  b32.instr_data, 32'hCAFEF00D);
    check("t5_pc",    b32.instr_pc, 32'hFFFF_FFFC);
    check("t5_req_o", b32.mem_req, 0);
    b32.instr_ready = 1'b1;
    tick();
    b32.instr_ready = 1'b0;
    check("t5_wrap_addr", b32.mem_addr, 32'h0);
    check("t5_wrap_req",  b32.mem_req, 1);
    b32.mem_ack = 1'b1; b32.mem_rdata = 32'hDEADDEAD;
    b32.redirect_valid = 1'b1; b32.redirect_pc = 32'h41;
    tick();
    b32.mem_ack = 1'b0; b32.redirect_valid = 1'b0;
    check("t5_rd_addr",  b32.mem_addr, 32'h40);
    check("t5_rd_valid", b32.instr_valid, 0);
    check("t5_rd_req",   b32.mem_req, 1);
    b32.mem_ack = 1'b1; b32.mem_rdata = 32'h12345678;
    tick();
    b32.mem_ack = 1'b0;
    check("t5_rd_data", b32.instr_data, 32'h12345678);
    check("t5_rd_pc",   b32.instr_pc, 32'h40);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
